// File: rtl/audio_frame_fifo.sv
// Multi-channel audio frame FIFO with a registered output frame, output hold and sticky overflow/underflow flags.
// Optional feature: define AUDIO_FIFO_UNDERFLOW_MUTE_EN to output silence on an underflowing pop instead of repeating the last frame.
module audio_frame_fifo #(
  parameter int DATA_W   = 24,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 8
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         in_valid,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         in_ready,
  input  logic                         out_req,
  input  logic                         hold_output,
  input  logic                         clear_flags,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         out_valid,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int FW = CHANNELS * DATA_W;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [LW-1:0] lvl_t;
  typedef logic [FW-1:0] frame_t;

  // DEPTH is a power of two, so dropping the carry gives the modulo wrap.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

  frame_t mem_q [DEPTH];

  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  lvl_t   level_q, level_d;
  frame_t out_data_q, out_data_d;
  logic   out_valid_q, out_valid_d;
  logic   overflow_q, overflow_d;
  logic   underflow_q, underflow_d;

  logic full, empty;
  logic push, drop, pop_req, pop, under;

  // Full/empty come from the pre-edge occupancy, so a same-cycle pop cannot make room
  // for a push and a same-cycle push cannot satisfy a pop.
  assign full    = (level_q == lvl_t'(DEPTH));
  assign empty   = (level_q == '0);
  assign push    = in_valid && !full;
  assign drop    = in_valid && full;
  assign pop_req = out_req && !hold_output;
  assign pop     = pop_req && !empty;
  assign under   = pop_req && empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;

    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d    = ptr_inc(rd_ptr_q);
      out_data_d  = mem_q[rd_ptr_q];
      out_valid_d = 1'b1;
    end

`ifdef AUDIO_FIFO_UNDERFLOW_MUTE_EN
    if (under) begin
      out_data_d = '0;
    end
`endif

    unique case ({push, pop})
      2'b10:   level_d = level_q + lvl_t'(1);
      2'b01:   level_d = level_q - lvl_t'(1);
      default: level_d = level_q;
    endcase
  end

  // A fresh event in the same cycle as clear_flags keeps the flag set.
  always_comb begin
    overflow_d  = drop  || (overflow_q  && !clear_flags);
    underflow_d = under || (underflow_q && !clear_flags);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Frame storage carries no reset; occupancy is governed by the pointers alone.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready  = !full;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_audio_frame_fifo.sv
// Scoreboard bench for audio_frame_fifo: accepted frames are queued at drive time and popped when out_valid appears.
module tb_audio_frame_fifo;

  localparam int DATA_W   = 24;
  localparam int CHANNELS = 2;
  localparam int DEPTH    = 8;
  localparam int FW       = CHANNELS * DATA_W;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          in_valid, out_req, hold_output, clear_flags;
  logic [FW-1:0] in_data;
  logic          in_ready, out_valid, overflow, underflow;
  logic [FW-1:0] out_data;
  logic [3:0]    level;

  int            vectors = 0;
  int            miscompares = 0;

  logic [FW-1:0] q[$];
  int            m_level = 0;
  logic [FW-1:0] m_last = '0;
  logic [FW-1:0] exp_f;

  audio_frame_fifo #(.DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_req(out_req), .hold_output(hold_output), .clear_flags(clear_flags),
    .out_data(out_data), .out_valid(out_valid), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 CLK = ~CLK;

  function automatic logic [FW-1:0] mk(input int l, input int r);
    return {DATA_W'(r), DATA_W'(l)};
  endfunction

  // Applies one cycle of stimulus, updates the FIFO model, returns whether a pop is expected.
  task automatic drive(input bit v, input logic [FW-1:0] d, input bit req, input bit hold,
                       input bit clr, output bit ev);
    bit full, empty, push, pop, und;
    in_valid = v; in_data = d; out_req = req; hold_output = hold; clear_flags = clr;
    full  = (m_level == DEPTH);
    empty = (m_level == 0);
    push  = v && !full;
    pop   = req && !hold && !empty;
    und   = req && !hold && empty;
    @(posedge CLK); #1;
    if (push) q.push_back(d);
    m_level = m_level + int'(push) - int'(pop);
`ifdef AUDIO_FIFO_UNDERFLOW_MUTE_EN
    if (und) m_last = '0;
`else
    if (und) m_last = m_last;
`endif
    ev = pop;
  endtask

  task automatic test_reset();
    nRST = 1'b0; in_valid = 0; in_data = '0; out_req = 0; hold_output = 0; clear_flags = 0;
    repeat (2) @(posedge CLK);
    #1;
    vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL reset_level got %0d want 0", level); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset_data got %0h want 0", out_data); end
    vectors++; if (out_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags got v%0b o%0b u%0b want 000", out_valid, overflow, underflow); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %0b want 1", in_ready); end
    @(negedge CLK); nRST = 1'b1;
  endtask

  task automatic test_order();
    bit ev;
    for (int i = 1; i <= 4; i++) begin
      drive(1, mk(i, i + 1), 0, 0, 0, ev);
      vectors++; if (level !== 4'(i)) begin miscompares++; $display("FAIL order_fill_level got %0d want %0d", level, i); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL order_fill_valid got %0b want 0", out_valid); end
    end
    for (int i = 1; i <= 4; i++) begin
      drive(0, '0, 1, 0, 0, ev);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL order_valid got %0b want 1", out_valid); end
      if (out_valid === 1'b1 && q.size() > 0) begin
        exp_f = q.pop_front(); m_last = exp_f;
        vectors++; if (out_data !== mk(i, i + 1)) begin miscompares++; $display("FAIL order_data got %0h want %0h", out_data, mk(i, i + 1)); end
      end
      vectors++; if (level !== 4'(4 - i)) begin miscompares++; $display("FAIL order_level got %0d want %0d", level, 4 - i); end
    end
    drive(0, '0, 0, 0, 0, ev);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL order_pulse got %0b want 0", out_valid); end
  endtask

  task automatic test_overflow();
    bit ev;
    for (int i = 1; i <= 9; i++) begin
      drive(1, mk(16'h100 + i, 16'h200 + i), 0, 0, 0, ev);
      if (i == 8) begin
        vectors++; if (level !== 4'd8) begin miscompares++; $display("FAIL ovf_level8 got %0d want 8", level); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ovf_ready got %0b want 0", in_ready); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early got %0b want 0", overflow); end
      end
    end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    vectors++; if (level !== 4'd8) begin miscompares++; $display("FAIL ovf_level9 got %0d want 8", level); end
    for (int i = 1; i <= 8; i++) begin
      drive(0, '0, 1, 0, 0, ev);
      vectors++; if (out_valid !== ev) begin miscompares++; $display("FAIL ovf_pop_valid got %0b want %0b", out_valid, ev); end
      if (ev && q.size() > 0) begin
        exp_f = q.pop_front(); m_last = exp_f;
        vectors++; if (out_data !== exp_f) begin miscompares++; $display("FAIL ovf_pop_data got %0h want %0h", out_data, exp_f); end
      end
    end
    drive(0, '0, 0, 0, 1, ev);
    vectors++; if (overflow !== 1'b0 || level !== 4'd0) begin
      miscompares++; $display("FAIL ovf_clear got o%0b l%0d want o0 l0", overflow, level); end
  endtask

  task automatic test_underflow();
    bit ev;
    drive(1, mk(24'h123456, 24'h654321), 0, 0, 0, ev);
    drive(0, '0, 1, 0, 0, ev);
    if (ev && q.size() > 0) begin exp_f = q.pop_front(); m_last = exp_f; end
    vectors++; if (out_data !== mk(24'h123456, 24'h654321)) begin
      miscompares++; $display("FAIL udf_last got %0h want %0h", out_data, mk(24'h123456, 24'h654321)); end
    drive(0, '0, 1, 0, 0, ev);
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL udf_flag got %0b want 1", underflow); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL udf_valid got %0b want 0", out_valid); end
`ifdef AUDIO_FIFO_UNDERFLOW_MUTE_EN
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL udf_data got %0h want 0", out_data); end
`else
    vectors++; if (out_data !== mk(24'h123456, 24'h654321)) begin
      miscompares++; $display("FAIL udf_data got %0h want %0h", out_data, mk(24'h123456, 24'h654321)); end
`endif
    drive(0, '0, 0, 0, 1, ev);
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL udf_clear got %0b want 0", underflow); end
  endtask

  task automatic test_hold();
    bit ev;
    for (int i = 0; i < 3; i++) begin
      drive(i < 2, mk(24'hA00 + i, 24'hB00 + i), 1, 1, 0, ev);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL hold_valid got %0b want 0", out_valid); end
      vectors++; if (out_data !== m_last) begin miscompares++; $display("FAIL hold_data got %0h want %0h", out_data, m_last); end
      vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL hold_udf got %0b want 0", underflow); end
    end
    vectors++; if (level !== 4'd2) begin miscompares++; $display("FAIL hold_level got %0d want 2", level); end
    for (int i = 0; i < 2; i++) begin
      drive(0, '0, 1, 0, 0, ev);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_rel_valid got %0b want 1", out_valid); end
      if (ev && q.size() > 0) begin
        exp_f = q.pop_front(); m_last = exp_f;
        vectors++; if (out_data !== mk(24'hA00 + i, 24'hB00 + i)) begin
          miscompares++; $display("FAIL hold_rel_data got %0h want %0h", out_data, mk(24'hA00 + i, 24'hB00 + i)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ev;
    for (int i = 0; i < 3; i++) drive(1, mk(24'hC00 + i, 24'hD00 + i), 0, 0, 0, ev);
    drive(1, mk(24'hC03, 24'hD03), 1, 0, 0, ev);
    vectors++; if (level !== 4'd3 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL b2b_level got l%0d v%0b want l3 v1", level, out_valid); end
    if (ev && q.size() > 0) begin
      exp_f = q.pop_front(); m_last = exp_f;
      vectors++; if (out_data !== mk(24'hC00, 24'hD00)) begin
        miscompares++; $display("FAIL b2b_data got %0h want %0h", out_data, mk(24'hC00, 24'hD00)); end
    end
    for (int i = 4; i < 9; i++) drive(1, mk(24'hC00 + i, 24'hD00 + i), 0, 0, 0, ev);
    vectors++; if (level !== 4'd8 || in_ready !== 1'b0) begin
      miscompares++; $display("FAIL b2b_full got l%0d r%0b want l8 r0", level, in_ready); end
    drive(1, mk(24'hEEE, 24'hFFF), 1, 0, 0, ev);
    vectors++; if (overflow !== 1'b1 || level !== 4'd7) begin
      miscompares++; $display("FAIL b2b_full_pushpop got o%0b l%0d want o1 l7", overflow, level); end
    while (q.size() > 0 || m_level > 0) begin
      vectors++; if (out_valid !== ev) begin miscompares++; $display("FAIL b2b_drain_valid got %0b want %0b", out_valid, ev); end
      if (ev && q.size() > 0) begin
        exp_f = q.pop_front(); m_last = exp_f;
        vectors++; if (out_data !== exp_f) begin miscompares++; $display("FAIL b2b_drain_data got %0h want %0h", out_data, exp_f); end
      end
      if (m_level == 0) break;
      drive(0, '0, 1, 0, 0, ev);
    end
    vectors++; if (out_valid !== ev) begin miscompares++; $display("FAIL b2b_last_valid got %0b want %0b", out_valid, ev); end
    if (ev && q.size() > 0) begin
      exp_f = q.pop_front(); m_last = exp_f;
      vectors++; if (out_data !== mk(24'hC08, 24'hD08)) begin
        miscompares++; $display("FAIL b2b_last_data got %0h want %0h", out_data, mk(24'hC08, 24'hD08)); end
    end
    drive(0, '0, 1, 0, 1, ev);
    vectors++; if (underflow !== 1'b1 || overflow !== 1'b0) begin
      miscompares++; $display("FAIL b2b_clear_race got u%0b o%0b want u1 o0", underflow, overflow); end
    drive(1, mk(24'h777, 24'h888), 1, 0, 1, ev);
    vectors++; if (underflow !== 1'b1 || level !== 4'd1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_empty_pushpop got u%0b l%0d v%0b want u1 l1 v0", underflow, level, out_valid); end
    drive(0, '0, 1, 0, 1, ev);
    if (ev && q.size() > 0) begin
      exp_f = q.pop_front(); m_last = exp_f;
      vectors++; if (out_data !== mk(24'h777, 24'h888) || underflow !== 1'b0) begin
        miscompares++; $display("FAIL b2b_stored got %0h u%0b want %0h u0", out_data, underflow, mk(24'h777, 24'h888)); end
    end
  endtask

  task automatic test_async_reset();
    bit ev;
    for (int i = 0; i < 6; i++) drive(1, mk(24'h500 + i, 24'h600 + i), 0, 0, 0, ev);
    drive(0, '0, 1, 0, 0, ev);
    if (ev && q.size() > 0) begin exp_f = q.pop_front(); m_last = exp_f; end
    vectors++; if (level !== 4'd5 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL arst_pre got l%0d v%0b want l5 v1", level, out_valid); end
    in_valid = 0; out_req = 0;
    #2 nRST = 1'b0;
    #1;
    vectors++; if (level !== 4'd0 || out_valid !== 1'b0 || out_data !== '0) begin
      miscompares++; $display("FAIL arst_now got l%0d v%0b d%0h want l0 v0 d0", level, out_valid, out_data); end
    vectors++; if (in_ready !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      miscompares++; $display("FAIL arst_flags got r%0b o%0b u%0b want r1 o0 u0", in_ready, overflow, underflow); end
    q.delete(); m_level = 0; m_last = '0;
    @(negedge CLK); nRST = 1'b1;
    drive(0, '0, 1, 0, 0, ev);
    vectors++; if (underflow !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      miscompares++; $display("FAIL arst_udf got u%0b v%0b d%0h want u1 v0 d0", underflow, out_valid, out_data); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_overflow();
    test_underflow();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
